// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller: per-pin input/push-pull/open-drain output drive, input
// synchroniser, glitch filter and W1C rise/fall edge interrupts.
module gpio_pad_ctrl #(
  parameter int unsigned PIN_COUNT    = 15,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned FILTER_WIDTH = 8
) (
  input  logic                     io_sys_clock,
  input  logic                     io_sys_reset,
  input  logic [PIN_COUNT-1:0]     io_pad_read,
  output logic [PIN_COUNT-1:0]     io_pad_write,
  output logic [PIN_COUNT-1:0]     io_pad_writeEnable,
  input  logic [PIN_COUNT-1:0]     io_out_value,
  input  logic [2*PIN_COUNT-1:0]   io_mode,
  input  logic [FILTER_WIDTH-1:0]  io_filterLimit,
  output logic [PIN_COUNT-1:0]     io_in_value,
  input  logic [PIN_COUNT-1:0]     io_irq_riseEn,
  input  logic [PIN_COUNT-1:0]     io_irq_fallEn,
  input  logic [PIN_COUNT-1:0]     io_irq_clear,
  output logic [PIN_COUNT-1:0]     io_irq_pending,
  output logic                     io_irq
);

  localparam logic [1:0] MODE_PUSH_PULL  = 2'b01;
  localparam logic [1:0] MODE_OPEN_DRAIN = 2'b10;

  logic [PIN_COUNT-1:0]    r_pad_write;
  logic [PIN_COUNT-1:0]    r_pad_we;
  logic [PIN_COUNT-1:0]    r_sync [SYNC_STAGES];
  logic [FILTER_WIDTH-1:0] r_cnt [PIN_COUNT];
  logic [PIN_COUNT-1:0]    r_in_value;
  logic [PIN_COUNT-1:0]    r_prev;
  logic [PIN_COUNT-1:0]    r_pending;

  logic [PIN_COUNT-1:0]    w_pad_write;
  logic [PIN_COUNT-1:0]    w_pad_we;
  logic [PIN_COUNT-1:0]    w_sync;
  logic [FILTER_WIDTH-1:0] w_limit_m1;
  logic [PIN_COUNT-1:0]    w_set;

  // Per-pin drive decode; reserved mode behaves as input.
  always_comb begin
    w_pad_write = '0;
    w_pad_we    = '0;
    for (int i = 0; i < PIN_COUNT; i++) begin
      case (io_mode[2*i +: 2])
        MODE_PUSH_PULL: begin
          w_pad_write[i] = io_out_value[i];
          w_pad_we[i]    = 1'b1;
        end
        MODE_OPEN_DRAIN: begin
          w_pad_write[i] = 1'b0;
          w_pad_we[i]    = ~io_out_value[i];
        end
        default: begin
          w_pad_write[i] = 1'b0;
          w_pad_we[i]    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge io_sys_clock or negedge io_sys_reset) begin
    if (!io_sys_reset) begin
      r_pad_write <= '0;
      r_pad_we    <= '0;
    end else begin
      r_pad_write <= w_pad_write;
      r_pad_we    <= w_pad_we;
    end
  end

  always_ff @(posedge io_sys_clock or negedge io_sys_reset) begin
    if (!io_sys_reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= io_pad_read;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // A limit of 0 is treated as 1, so the threshold L-1 bottoms out at 0.
  assign w_limit_m1 = (io_filterLimit == '0) ? '0
                                             : io_filterLimit - FILTER_WIDTH'(1);

  // Threshold is compared with >= so a lowered limit takes effect at once.
  always_ff @(posedge io_sys_clock or negedge io_sys_reset) begin
    if (!io_sys_reset) begin
      r_in_value <= '0;
      for (int i = 0; i < PIN_COUNT; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < PIN_COUNT; i++) begin
        if (w_sync[i] == r_in_value[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] >= w_limit_m1) begin
          r_in_value[i] <= w_sync[i];
          r_cnt[i]      <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + FILTER_WIDTH'(1);
        end
      end
    end
  end

  assign w_set = (~r_prev & r_in_value & io_irq_riseEn)
               | (r_prev & ~r_in_value & io_irq_fallEn);

  // New events win over a coincident clear.
  always_ff @(posedge io_sys_clock or negedge io_sys_reset) begin
    if (!io_sys_reset) begin
      r_prev    <= '0;
      r_pending <= '0;
    end else begin
      r_prev    <= r_in_value;
      r_pending <= (r_pending & ~io_irq_clear) | w_set;
    end
  end

  assign io_pad_write       = r_pad_write;
  assign io_pad_writeEnable = r_pad_we;
  assign io_in_value        = r_in_value;
  assign io_irq_pending     = r_pending;
  assign io_irq             = |r_pending;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Self-checking bench for gpio_pad_ctrl: directed literal checks plus random
// stimulus compared every cycle against a behavioural model.
module tb_gpio_pad_ctrl;

  localparam int unsigned N  = 15;
  localparam int unsigned S  = 2;
  localparam int unsigned FW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    pad, out_v, rise_en, fall_en, clr;
  logic [2*N-1:0]  mode;
  logic [FW-1:0]   limit;
  logic [N-1:0]    wr, we, in_v, pend;
  logic            irq;

  int checks   = 0;
  int failures = 0;

  gpio_pad_ctrl #(.PIN_COUNT(N), .SYNC_STAGES(S), .FILTER_WIDTH(FW)) dut (
    .io_sys_clock      (clk),
    .io_sys_reset      (rst_n),
    .io_pad_read       (pad),
    .io_pad_write      (wr),
    .io_pad_writeEnable(we),
    .io_out_value      (out_v),
    .io_mode           (mode),
    .io_filterLimit    (limit),
    .io_in_value       (in_v),
    .io_irq_riseEn     (rise_en),
    .io_irq_fallEn     (fall_en),
    .io_irq_clear      (clr),
    .io_irq_pending    (pend),
    .io_irq            (irq)
  );

  always #5 clk = ~clk;

  // Behavioural model: pad history as a delay line, per-pin run length of
  // disagreement, accept a new level once the run reaches the limit.
  logic [N-1:0] m_hist [S];
  int           m_run  [N];
  logic [N-1:0] m_in, m_prev, m_pend, m_wr, m_we;

  always @(posedge clk or negedge rst_n) begin : model
    logic [N-1:0] sync_v, nin, set_v;
    logic [1:0]   md;
    int           lim;
    if (!rst_n) begin
      for (int s = 0; s < S; s++) m_hist[s] = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      m_in = '0; m_prev = '0; m_pend = '0; m_wr = '0; m_we = '0;
    end else begin
      lim    = (limit == 0) ? 1 : int'(limit);
      sync_v = m_hist[S-1];
      nin    = m_in;
      for (int i = 0; i < N; i++) begin
        if (sync_v[i] == m_in[i]) m_run[i] = 0;
        else begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] >= lim) begin
            nin[i]   = sync_v[i];
            m_run[i] = 0;
          end
        end
      end
      set_v  = (~m_prev & m_in & rise_en) | (m_prev & ~m_in & fall_en);
      m_pend = (m_pend & ~clr) | set_v;
      m_prev = m_in;
      m_in   = nin;
      for (int s = S - 1; s > 0; s--) m_hist[s] = m_hist[s-1];
      m_hist[0] = pad;
      for (int i = 0; i < N; i++) begin
        md = mode[2*i +: 2];
        case (md)
          2'b01:   begin m_wr[i] = out_v[i]; m_we[i] = 1'b1;      end
          2'b10:   begin m_wr[i] = 1'b0;     m_we[i] = ~out_v[i]; end
          default: begin m_wr[i] = 1'b0;     m_we[i] = 1'b0;      end
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_write",    32'(wr),   32'(m_wr));
    chk("model_we",       32'(we),   32'(m_we));
    chk("model_in_value", 32'(in_v), 32'(m_in));
    chk("model_pending",  32'(pend), 32'(m_pend));
    chk("model_irq",      32'(irq),  32'(|m_pend));
  end

  // Count rising edges until in_v[pin] reaches val; -1 on timeout.
  task automatic wait_in(input int pin, input logic val, output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (in_v[pin] === val) begin
        n = k;
        return;
      end
    end
  endtask

  int n;

  initial begin
    rst_n = 1'b0; pad = '0; out_v = '0; rise_en = '0; fall_en = '0; clr = '0;
    mode = '0; limit = 8'd4;

    // Reset held with pads toggling and drive modes requested.
    mode = {N{2'b01}}; out_v = '1; rise_en = '1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1 pad = N'($urandom);
      @(posedge clk); #1;
      chk("rst_we", 32'(we), 0);
      chk("rst_write", 32'(wr), 0);
      chk("rst_in_value", 32'(in_v), 0);
      chk("rst_irq", 32'(irq), 0);
    end
    @(negedge clk); #1 pad = '0; mode = '0; out_v = '0; rise_en = '0;
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_pending", 32'(pend), 0);
    chk("post_rst_irq", 32'(irq), 0);

    // Output modes on pin 3.
    @(negedge clk); #1 out_v[3] = 1'b1; mode[7:6] = 2'b01;
    @(posedge clk); #1;
    chk("pp_write3", 32'(wr[3]), 1);
    chk("pp_we3", 32'(we[3]), 1);
    mode[7:6] = 2'b10;
    @(posedge clk); #1;
    chk("od1_write3", 32'(wr[3]), 0);
    chk("od1_we3", 32'(we[3]), 0);
    out_v[3] = 1'b0;
    @(posedge clk); #1;
    chk("od0_we3", 32'(we[3]), 1);
    chk("od0_write3", 32'(wr[3]), 0);
    mode[7:6] = 2'b11;
    @(posedge clk); #1;
    chk("rsv_we3", 32'(we[3]), 0);
    mode = '0;

    // Filter latency with limit 4: SYNC_STAGES + 4 = 6 edges.
    @(negedge clk); #1 pad[0] = 1'b1;
    wait_in(0, 1'b1, n);
    chk("lim4_latency", 32'(n), 6);

    // A 3-cycle glitch must be rejected and raise nothing.
    rise_en[2] = 1'b1;
    @(negedge clk); #1 pad[2] = 1'b1;
    repeat (3) @(negedge clk);
    #1 pad[2] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("glitch_in2", 32'(in_v[2]), 0);
    chk("glitch_pend2", 32'(pend[2]), 0);
    rise_en[2] = 1'b0;

    // Limit 0 and limit 1 both give SYNC_STAGES + 1 = 3 edges.
    limit = 8'd0;
    @(negedge clk); #1 pad[5] = 1'b1;
    wait_in(5, 1'b1, n);
    chk("lim0_latency", 32'(n), 3);
    limit = 8'd1;
    @(negedge clk); #1 pad[5] = 1'b0;
    wait_in(5, 1'b0, n);
    chk("lim1_latency", 32'(n), 3);

    // Interrupts on pin 7, rise only.
    limit = 8'd0; rise_en[7] = 1'b1;
    @(negedge clk); #1 pad[7] = 1'b1;
    wait_in(7, 1'b1, n);
    chk("irq_pend_not_yet", 32'(pend[7]), 0);
    @(posedge clk); #1;
    chk("irq_pend_rise", 32'(pend[7]), 1);
    chk("irq_line_rise", 32'(irq), 1);
    pad[7] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("irq_fall_in7", 32'(in_v[7]), 0);
    chk("irq_fall_pend", 32'(pend[7]), 1);
    @(negedge clk); #1 clr[7] = 1'b1;
    @(posedge clk); #1 clr[7] = 1'b0;
    chk("irq_clear_pend", 32'(pend[7]), 0);
    chk("irq_clear_line", 32'(irq), 0);
    pad[7] = 1'b1;
    wait_in(7, 1'b1, n);
    clr[7] = 1'b1;
    @(posedge clk); #1 clr[7] = 1'b0;
    chk("irq_set_wins", 32'(pend[7]), 1);
    clr[7] = 1'b1;
    @(posedge clk); #1 clr[7] = 1'b0;
    rise_en[7] = 1'b0;

    // Lowering the limit mid-count accepts on the next edge.
    limit = 8'd200;
    @(negedge clk); #1 pad[1] = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("limchg_before", 32'(in_v[1]), 0);
    limit = 8'd10;
    @(posedge clk); #1;
    chk("limchg_after", 32'(in_v[1]), 1);
    limit = 8'd2;

    // Random phase, checked against the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) pad[i] = ~pad[i];
      out_v = N'($urandom);
      clr   = N'($urandom & $urandom & $urandom);
      if (c % 50 == 0) begin
        mode    = 30'($urandom);
        rise_en = N'($urandom);
        fall_en = N'($urandom);
        limit   = FW'($urandom_range(0, 5));
      end
      if (c == 1500 || c == 2300) begin
        #1 rst_n = 1'b0;
        @(negedge clk); #1;
        chk("mid_rst_pending", 32'(pend), 0);
        chk("mid_rst_in_value", 32'(in_v), 0);
        #1 rst_n = 1'b1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
